// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
//   Handshake/data bundle between the pipeline (master) and the sequential
//   divider (slave).
//
//   ctrl_DIV        master -> slave  start pulse, operands sampled same edge
//   data_operandA   master -> slave  dividend, two's complement
//   data_operandB   master -> slave  divisor, two's complement
//   data_result     slave -> master  quotient, truncated toward zero
//   data_remainder  slave -> master  remainder, sign follows dividend
//   data_exception  slave -> master  divide-by-zero, valid with data_resultRDY
//   data_resultRDY  slave -> master  one-cycle result-valid pulse
// ---------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 32
) ();

    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_remainder,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_remainder,
        output data_exception,
        output data_resultRDY
    );

endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Multicycle signed integer divider for the ALU/multdiv path. Restoring
//   division on operand magnitudes, one quotient bit per clock; signs are
//   applied when the final step loads the outputs.
//
//   clock   in   system clock, rising edge
//   reset   in   synchronous, active-high
//   bus     slave modport of seq_divider_if (start, operands, results, RDY)
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | waiting for ctrl_DIV; outputs hold the last result
//   BUSY   | one restoring-division step per clock, down-counter running
//   DONE   | data_resultRDY high for exactly this one cycle
//
//   A capture with a zero divisor spends its single terminal cycle in BUSY
//   (counter loaded with zero) and loads the exception outputs there, so the
//   RDY pulse lands one cycle after capture just as a normal operation lands
//   WIDTH cycles after capture.
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    seq_divider_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   b_mag;
    logic             qsign;
    logic             rsign;
    logic             div_zero;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] remainder_q;
    logic             exception_q;

    // Magnitudes need WIDTH+1 bits so that -2^(WIDTH-1) maps to +2^(WIDTH-1).
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   a_abs;
    logic [WIDTH:0]   b_abs;
    logic             b_is_zero;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] trial;
    logic             fits;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             last_step;

    always_comb begin
        a_ext     = {bus.data_operandA[WIDTH-1], bus.data_operandA};
        b_ext     = {bus.data_operandB[WIDTH-1], bus.data_operandB};
        a_abs     = bus.data_operandA[WIDTH-1] ? -a_ext : a_ext;
        b_abs     = bus.data_operandB[WIDTH-1] ? -b_ext : b_ext;
        b_is_zero = (bus.data_operandB == '0);
    end

    // Trial subtraction r - b as r + ~b + 1; the carry out of bit WIDTH is
    // set exactly when r >= b, i.e. the subtraction does not borrow.
    always_comb begin
        r_shift   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial     = {1'b0, r_shift} + {1'b0, ~b_mag} + (WIDTH+2)'(1);
        fits      = trial[WIDTH+1];
        rem_step  = fits ? trial[WIDTH:0] : r_shift;
        quo_step  = {quo[WIDTH-2:0], fits};
        last_step = (count == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start pulse restarts from any state; holding it high keeps the
    // divider re-capturing, so DONE is never reached until it drops.
    always_comb begin
        state_nxt = state;
        if (bus.ctrl_DIV) begin
            state_nxt = S_BUSY;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_BUSY:  state_nxt = last_step ? S_DONE : S_BUSY;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            quo         <= '0;
            rem         <= '0;
            b_mag       <= '0;
            qsign       <= 1'b0;
            rsign       <= 1'b0;
            div_zero    <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
        end else if (bus.ctrl_DIV) begin
            quo      <= a_abs[WIDTH-1:0];
            b_mag    <= b_abs;
            rem      <= '0;
            qsign    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            rsign    <= bus.data_operandA[WIDTH-1];
            div_zero <= b_is_zero;
            count    <= b_is_zero ? '0 : CNT_W'(WIDTH - 1);
        end else if (state == S_BUSY) begin
            quo <= quo_step;
            rem <= rem_step;
            if (last_step) begin
                if (div_zero) begin
                    result_q    <= '0;
                    remainder_q <= '0;
                    exception_q <= 1'b1;
                end else begin
                    result_q    <= qsign ? -quo_step : quo_step;
                    remainder_q <= rsign ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
                    exception_q <= 1'b0;
                end
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_remainder = remainder_q;
    assign bus.data_exception = exception_q;
    assign bus.data_resultRDY = (state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider: directed corner cases followed by
//   random operand pairs, compared against plain signed 64-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_seq_divider;

    localparam int WIDTH = 32;
    localparam int LAT_LIMIT = 40;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: quotient truncates toward zero, remainder takes the
    // dividend's sign; the only overflow case wraps to the low WIDTH bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
            e = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            e  = 1'b0;
        end
    endfunction

    // Returns at the falling edge just after the capture edge.
    task automatic pulse(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_DIV      = 1'b0;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        while (bus.data_resultRDY !== 1'b1 && lat < LAT_LIMIT) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic watch_no_rdy(input int cycles, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag, input int lat, input int exp_lat,
                                 input logic [31:0] q, input logic [31:0] r, input logic e);
        check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":result"}, bus.data_result, q);
        check({tag, ":remainder"}, bus.data_remainder, r);
        check({tag, ":exception"}, bus.data_exception, e);
        @(negedge clock);
        check({tag, ":rdy_pulse"}, bus.data_resultRDY, 1'b0);
        check({tag, ":hold"}, bus.data_result, q);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b);
        int         lat;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        model(a, b, q, r, e);
        pulse(a, b);
        wait_rdy(lat);
        check_outputs(tag, lat, (b == 32'd0) ? 1 : WIDTH, q, r, e);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;

        reset             = 1'b1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("reset:result", bus.data_result, 32'd0);
        check("reset:remainder", bus.data_remainder, 32'd0);
        check("reset:exception", bus.data_exception, 1'b0);
        check("reset:rdy", bus.data_resultRDY, 1'b0);

        // Reset beats a start pulse on the same edge.
        @(negedge clock);
        reset             = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd20;
        bus.data_operandB = 32'd4;
        @(negedge clock);
        reset        = 1'b0;
        bus.ctrl_DIV = 1'b0;
        watch_no_rdy(LAT_LIMIT, seen);
        check("reset_wins:no_rdy", seen, 1'b0);

        run_div("t1_100_7", 32'd100, 32'd7);
        run_div("t2_m100_7", -32'sd100, 32'd7);
        run_div("t2_100_m7", 32'd100, -32'sd7);
        run_div("t2_m100_m7", -32'sd100, -32'sd7);
        run_div("t3_5_0", 32'd5, 32'd0);
        run_div("t3_9_3", 32'd9, 32'd3);
        run_div("t4_min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("t4_min_2", 32'h8000_0000, 32'd2);
        run_div("min_min", 32'h8000_0000, 32'h8000_0000);
        run_div("small_big", 32'd3, 32'h8000_0000);
        run_div("max_1", 32'h7FFF_FFFF, 32'd1);
        run_div("zero_dividend", 32'd0, -32'sd5);

        // Restart mid-operation: only the second operation reports.
        pulse(32'd1000, 32'd10);
        watch_no_rdy(14, seen);
        check("t5:no_early_rdy", seen, 1'b0);
        model(32'd81, 32'd9, q, r, e);
        pulse(32'd81, 32'd9);
        wait_rdy(lat);
        check_outputs("t5_restart", lat, WIDTH, q, r, e);

        // Reset mid-operation aborts silently and clears the outputs.
        pulse(32'd50, 32'd5);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        watch_no_rdy(LAT_LIMIT, seen);
        check("t6:no_rdy", seen, 1'b0);
        check("t6:result", bus.data_result, 32'd0);
        check("t6:remainder", bus.data_remainder, 32'd0);
        check("t6:exception", bus.data_exception, 1'b0);
        run_div("t6_50_5", 32'd50, 32'd5);

        // ctrl_DIV held high keeps restarting; the last capture completes.
        @(negedge clock);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = -32'sd77;
        bus.data_operandB = 32'd6;
        watch_no_rdy(LAT_LIMIT, seen);
        check("held:no_rdy", seen, 1'b0);
        bus.ctrl_DIV = 1'b0;
        model(-32'sd77, 32'd6, q, r, e);
        wait_rdy(lat);
        check_outputs("held_release", lat, WIDTH, q, r, e);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = -32'($urandom_range(1, 255));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            if (b == 32'd0) b = 32'd1;
            run_div("rand", a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
